// File: rtl/controle_medicao_pkg.sv
// Shared types and constants for the level-measurement sequencer.
// State encoding, classifier class codes, sample index width and a
// saturating increment used by the round and sample counters.
package controle_medicao_pkg;

  localparam int ESTADO_W = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO     = 4'd0,
    LIMPA      = 4'd1,
    PEDE       = 4'd2,
    ESPERA     = 4'd3,
    INTERVALO  = 4'd4,
    CLASSIFICA = 4'd5,
    AGUARDA    = 4'd6,
    AVALIA     = 4'd7,
    CONCLUI    = 4'd8,
    FALHA      = 4'd9,
    ERRO       = 4'd10
  } estado_t;

  localparam logic [2:0] CLASSE_BAIXO   = 3'b001;
  localparam logic [2:0] CLASSE_NORMAL  = 3'b100;
  localparam logic [2:0] CLASSE_ALTO    = 3'b010;
  localparam logic [2:0] CLASSE_CRITICO = 3'b011;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [IDX_W-1:0] inc_sat(input logic [IDX_W-1:0] v);
    if (v == {IDX_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/controle_medicao_contador_espera.sv
// Loadable down-counter with a done flag. A single instance serves both the
// sample timeout and the inter-sample interval, which never overlap.
module contador_espera
  import controle_medicao_pkg::*;
#(
  parameter int LARGURA = 16
) (
  input  logic               clock,
  input  logic               zera_n,
  input  logic               carregar,
  input  logic [LARGURA-1:0] valor,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  // Load a fresh wait length, otherwise count down and stop at zero.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      contagem <= '0;
    end else if (carregar) begin
      contagem <= valor;
    end else if (contagem != '0) begin
      contagem <= contagem - LARGURA'(1);
    end
  end

  assign fim = (contagem == '0);

endmodule

// File: rtl/controle_medicao.sv
// Top-level sequencer of the measurement path: requests three spaced sensor
// samples, runs the classifier, retries discarded or timed-out rounds and
// publishes the final average and class.
// Optional feature: define MODO_CONTINUO_EN to add the 'continuo' input,
// which restarts a new measurement after each publish instead of idling.
module controle_medicao
  import controle_medicao_pkg::*;
#(
  parameter int MAX_TENTATIVAS   = 3,
  parameter int TIMEOUT_CICLOS   = 50000,
  parameter int INTERVALO_CICLOS = 1000
) (
  input  logic        clock,
  input  logic        zera_n,
  input  logic        iniciar,
  input  logic        medida_pronta,
  input  logic [11:0] medida_in,
  input  logic        fim_classificacao,
  input  logic        descartar_medida,
  input  logic [11:0] media_in,
  input  logic [2:0]  classe_in,
`ifdef MODO_CONTINUO_EN
  input  logic        continuo,
`endif
  output logic        pedir_medida,
  output logic [11:0] medida1,
  output logic [11:0] medida2,
  output logic [11:0] medida3,
  output logic        zera_classif,
  output logic        iniciar_classif,
  output logic [11:0] resultado_media,
  output logic [2:0]  resultado_classe,
  output logic        resultado_valido,
  output logic        erro,
  output logic        ocupado,
  output logic [1:0]  tentativas
);

  localparam int MAX_CICLOS = (TIMEOUT_CICLOS > INTERVALO_CICLOS) ? TIMEOUT_CICLOS : INTERVALO_CICLOS;
  localparam int CONT_W     = $clog2(MAX_CICLOS + 1);
  // Loads are one less than the wait length because the zero count is itself a waiting cycle.
  localparam logic [CONT_W-1:0] CARGA_TIMEOUT   = CONT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CONT_W-1:0] CARGA_INTERVALO = CONT_W'(INTERVALO_CICLOS - 1);
  localparam logic [1:0]        LIMITE          = 2'(MAX_TENTATIVAS);

  estado_t            estado;
  estado_t            proximo;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [1:0]         tentativas_inc;
  logic               espera_fim;
  logic               carregar;
  logic [CONT_W-1:0]  carga;
  logic               modo_continuo;

`ifdef MODO_CONTINUO_EN
  assign modo_continuo = continuo;
`else
  assign modo_continuo = 1'b0;
`endif

  assign idx_inc        = inc_sat(idx);
  assign tentativas_inc = inc_sat(tentativas);

  contador_espera #(.LARGURA(CONT_W)) u_espera (
    .clock    (clock),
    .zera_n   (zera_n),
    .carregar (carregar),
    .valor    (carga),
    .fim      (espera_fim)
  );

  // Next-state decode; also loads the shared wait counter on entry to a wait.
  always_comb begin
    proximo  = estado;
    carregar = 1'b0;
    carga    = '0;
    case (estado)
      OCIOSO: begin
        if (iniciar) proximo = LIMPA;
        else         proximo = OCIOSO;
      end
      LIMPA: proximo = PEDE;
      PEDE: begin
        proximo  = ESPERA;
        carregar = 1'b1;
        carga    = CARGA_TIMEOUT;
      end
      ESPERA: begin
        // A sample arriving on the last timeout cycle still counts.
        if (medida_pronta) begin
          if (idx_inc == 2'd3) begin
            proximo = CLASSIFICA;
          end else begin
            proximo  = INTERVALO;
            carregar = 1'b1;
            carga    = CARGA_INTERVALO;
          end
        end else if (espera_fim) begin
          proximo = FALHA;
        end else begin
          proximo = ESPERA;
        end
      end
      INTERVALO: begin
        if (espera_fim) proximo = PEDE;
        else            proximo = INTERVALO;
      end
      CLASSIFICA: proximo = AGUARDA;
      AGUARDA: begin
        if (fim_classificacao) proximo = AVALIA;
        else                   proximo = AGUARDA;
      end
      AVALIA: begin
        if (descartar_medida) proximo = FALHA;
        else                  proximo = CONCLUI;
      end
      CONCLUI: begin
        if (modo_continuo) begin
          proximo  = INTERVALO;
          carregar = 1'b1;
          carga    = CARGA_INTERVALO;
        end else begin
          proximo = OCIOSO;
        end
      end
      FALHA: begin
        if (tentativas_inc == LIMITE) proximo = ERRO;
        else                          proximo = LIMPA;
      end
      ERRO: begin
        if (iniciar) proximo = LIMPA;
        else         proximo = ERRO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Sample latches, round counter and published result.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      idx              <= '0;
      tentativas       <= 2'd0;
      medida1          <= 12'd0;
      medida2          <= 12'd0;
      medida3          <= 12'd0;
      resultado_media  <= 12'd0;
      resultado_classe <= 3'd0;
      resultado_valido <= 1'b0;
    end else begin
      resultado_valido <= (estado == CONCLUI);
      case (estado)
        LIMPA: idx <= '0;
        ESPERA: begin
          if (medida_pronta) begin
            case (idx)
              2'd0:    medida1 <= medida_in;
              2'd1:    medida2 <= medida_in;
              2'd2:    medida3 <= medida_in;
              default: ;
            endcase
            idx <= idx_inc;
          end
        end
        CONCLUI: begin
          resultado_media  <= media_in;
          resultado_classe <= classe_in;
          tentativas       <= 2'd0;
          idx              <= '0;
        end
        FALHA: tentativas <= tentativas_inc;
        ERRO: begin
          if (iniciar) tentativas <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign pedir_medida    = (estado == PEDE);
  assign iniciar_classif = (estado == CLASSIFICA);
  assign zera_classif    = ~zera_n | (estado == LIMPA);
  assign erro            = (estado == ERRO);
  assign ocupado         = (estado != OCIOSO) && (estado != ERRO);

endmodule

// File: tb/tb_controle_medicao.sv
// Self-checking bench for controle_medicao: behavioural sensor and classifier
// responders plus a per-measurement model of rounds, retries and publishes.
module tb_controle_medicao;
  import controle_medicao_pkg::*;

  localparam int T = 200;
  localparam int I = 20;
  localparam int M = 3;

  logic        clock = 1'b0;
  logic        zera_n, iniciar, medida_pronta, fim_classificacao, descartar_medida;
  logic [11:0] medida_in, media_in;
  logic [2:0]  classe_in;
`ifdef MODO_CONTINUO_EN
  logic        continuo = 1'b0;
`endif
  logic        pedir_medida, zera_classif, iniciar_classif, resultado_valido, erro, ocupado;
  logic [11:0] medida1, medida2, medida3, resultado_media;
  logic [2:0]  resultado_classe;
  logic [1:0]  tentativas;

  typedef struct {
    logic        d;
    logic [11:0] media;
    logic [2:0]  classe;
  } rodada_t;

  int n_checks = 0;
  int n_err = 0;
  int ciclo = 0;
  int rs[3];
  int rs_n = 0;
  int mudos_pend = 0;
  bit mute_ativo = 1'b0;
  int mute_ciclo = 0;
  int pronta_ciclo = 0;
  int falhas_model = 0;
  bit clas_mudo = 1'b0;
  bit espurio = 1'b0;
  int n_pedir = 0, n_zera = 0, n_valid = 0;
  logic [11:0] ultimo_media = 12'd0;
  rodada_t cls_q[$];
  rodada_t exp_q[$];
  logic [11:0] amostras_q[$];

  controle_medicao #(
    .MAX_TENTATIVAS(M), .TIMEOUT_CICLOS(T), .INTERVALO_CICLOS(I)
  ) dut (
    .clock(clock), .zera_n(zera_n), .iniciar(iniciar),
    .medida_pronta(medida_pronta), .medida_in(medida_in),
    .fim_classificacao(fim_classificacao), .descartar_medida(descartar_medida),
    .media_in(media_in), .classe_in(classe_in),
`ifdef MODO_CONTINUO_EN
    .continuo(continuo),
`endif
    .pedir_medida(pedir_medida), .medida1(medida1), .medida2(medida2), .medida3(medida3),
    .zera_classif(zera_classif), .iniciar_classif(iniciar_classif),
    .resultado_media(resultado_media), .resultado_classe(resultado_classe),
    .resultado_valido(resultado_valido), .erro(erro), .ocupado(ocupado),
    .tentativas(tentativas)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    assert (obs === esp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  // Sensor: answers each request after a random latency, or stays silent when muted.
  initial begin
    medida_pronta = 1'b0;
    medida_in = 12'd0;
    forever begin
      @(negedge clock);
      if (zera_classif) rs_n = 0;
      if (espurio) begin
        espurio = 1'b0;
        medida_in = 12'habc;
        medida_pronta = 1'b1;
        @(negedge clock);
        medida_pronta = 1'b0;
      end else if (pedir_medida) begin
        n_pedir++;
        if (mute_ativo) begin
          chk("timeout_gap", ciclo - mute_ciclo, T + 3);
          mute_ativo = 1'b0;
        end else if (rs_n == 1 || rs_n == 2) begin
          chk("intervalo_gap", ciclo - pronta_ciclo, I + 1);
        end
        if (mudos_pend > 0) begin
          mudos_pend--;
          mute_ativo = 1'b1;
          mute_ciclo = ciclo;
          falhas_model++;
        end else begin
          repeat ($urandom_range(1, 8)) @(negedge clock);
          if (amostras_q.size() > 0) medida_in = amostras_q.pop_front();
          else                       medida_in = 12'($urandom_range(0, 4095));
          if (rs_n < 3) begin
            rs[rs_n] = int'(medida_in);
            rs_n++;
          end
          pronta_ciclo = ciclo;
          medida_pronta = 1'b1;
          @(negedge clock);
          medida_pronta = 1'b0;
        end
      end
    end
  end

  // Classifier: sticky done two cycles after start, cleared by zera_classif.
  initial begin
    rodada_t r;
    fim_classificacao = 1'b0;
    descartar_medida = 1'b0;
    media_in = 12'd0;
    classe_in = 3'd0;
    forever begin
      @(negedge clock);
      if (zera_classif) begin
        fim_classificacao = 1'b0;
      end else if (iniciar_classif && !clas_mudo) begin
        chk("medida1", medida1, rs[0]);
        chk("medida2", medida2, rs[1]);
        chk("medida3", medida3, rs[2]);
        chk("tentativas_rodada", tentativas, falhas_model);
        if (cls_q.size() > 0) r = cls_q.pop_front();
        else begin r.d = 1'b0; r.media = 12'd0; r.classe = 3'd0; end
        repeat (2) @(negedge clock);
        media_in = r.media;
        classe_in = r.classe;
        descartar_medida = r.d;
        fim_classificacao = 1'b1;
        if (r.d) falhas_model++;
      end
    end
  end

  // Publish monitor and event counters.
  initial begin
    rodada_t e;
    forever begin
      @(negedge clock);
      if (zera_n && zera_classif) n_zera++;
      if (resultado_valido) begin
        n_valid++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resultado_media", resultado_media, e.media);
          chk("resultado_classe", resultado_classe, e.classe);
        end else begin
          chk("publicacao_inesperada", resultado_valido, 0);
        end
        chk("tentativas_publicacao", tentativas, 0);
      end
    end
  end

  // One full measurement: model derives rounds, retries and outcome from the discard pattern.
  task automatic medir(input logic [2:0] desc, input int mudos, input bit fixo,
                       input logic [11:0] m_fix, input logic [2:0] c_fix);
    int fails, cls_rounds, p0, z0, v0, k;
    bit ok;
    rodada_t r;
    cls_q.delete();
    exp_q.delete();
    fails = mudos;
    cls_rounds = 0;
    ok = 1'b0;
    while (fails < M && !ok) begin
      r.d = desc[cls_rounds];
      r.media = fixo ? m_fix : 12'($urandom_range(0, 4095));
      r.classe = fixo ? c_fix : 3'($urandom_range(0, 7));
      cls_q.push_back(r);
      cls_rounds++;
      if (r.d) fails++;
      else begin
        ok = 1'b1;
        exp_q.push_back(r);
        ultimo_media = r.media;
      end
    end
    falhas_model = 0;
    mudos_pend = mudos;
    p0 = n_pedir; z0 = n_zera; v0 = n_valid;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk("erro_limpo_no_inicio", erro, 0);
    chk("ocupado_no_inicio", ocupado, 1);
    k = 0;
    while (ocupado && k < 5000) begin
      iniciar = (k == 30);
      @(negedge clock);
      k++;
    end
    iniciar = 1'b0;
    chk("termina_no_prazo", k < 5000, 1);
    @(negedge clock);
    chk("erro_final", erro, !ok);
    chk("tentativas_final", tentativas, ok ? 0 : M);
    chk("ocupado_final", ocupado, 0);
    chk("pedidos", n_pedir - p0, 3 * cls_rounds + mudos);
    chk("limpezas", n_zera - z0, cls_rounds + mudos);
    chk("publicacoes", n_valid - v0, ok ? 1 : 0);
    chk("resultado_mantido", resultado_media, ultimo_media);
  endtask

  initial begin
    int k, v0;
    zera_n = 1'b0;
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pedir", pedir_medida, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro, 0);
    chk("rst_valido", resultado_valido, 0);
    chk("rst_media", resultado_media, 0);
    chk("rst_medida1", medida1, 0);
    chk("rst_tentativas", tentativas, 0);
    chk("rst_zera_classif", zera_classif, 1);
    chk("rst_iniciar_classif", iniciar_classif, 0);
    zera_n = 1'b1;
    @(negedge clock);
    chk("zera_classif_solto", zera_classif, 0);

    // Nominal measurement with fixed samples and result
    amostras_q.push_back(12'd100);
    amostras_q.push_back(12'd101);
    amostras_q.push_back(12'd102);
    medir(3'b000, 0, 1'b1, 12'd101, CLASSE_NORMAL);
    chk("t1_medida1", medida1, 100);
    chk("t1_medida3", medida3, 102);
    chk("t1_classe", resultado_classe, CLASSE_NORMAL);

    // First round discarded, second accepted
    medir(3'b001, 0, 1'b0, 12'd0, 3'd0);
    // All rounds discarded -> erro
    medir(3'b111, 0, 1'b0, 12'd0, 3'd0);
    // Timeout on the first sample, restarted from ERRO
    medir(3'b000, 1, 1'b0, 12'd0, 3'd0);

    // Reset while waiting for the classifier
    clas_mudo = 1'b1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    k = 0;
    while (!iniciar_classif && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk("t5_chega_classifica", k < 2000, 1);
    repeat (3) @(negedge clock);
    chk("t5_ocupado_antes", ocupado, 1);
    v0 = n_valid;
    zera_n = 1'b0;
    @(negedge clock);
    chk("t5_zera_classif", zera_classif, 1);
    chk("t5_ocupado", ocupado, 0);
    chk("t5_medida1", medida1, 0);
    chk("t5_medida3", medida3, 0);
    chk("t5_media", resultado_media, 0);
    chk("t5_tentativas", tentativas, 0);
    zera_n = 1'b1;
    clas_mudo = 1'b0;
    ultimo_media = 12'd0;
    espurio = 1'b1;
    repeat (5) @(negedge clock);
    chk("t5_espurio_ocupado", ocupado, 0);
    chk("t5_espurio_medida1", medida1, 0);
    chk("t5_espurio_pedir", pedir_medida, 0);
    chk("t5_sem_publicacao", n_valid - v0, 0);

    // Randomized measurements
    for (int j = 0; j < 8; j++) begin
      medir(3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0, 12'd0, 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
